// File: rtl/serial_to_parallel_l1_pkg.sv
// Shared constants for the L1 Rx stages: idle symbol, alignment depth
// and the link FSM state encoding.
package serial_to_parallel_l1_pkg;

  // Alignment / idle filler symbol
  localparam logic [7:0] RX_COMMA     = 8'hBC;
  // Consecutive COMMA words needed before the link is declared active
  localparam int         RX_BC_NEEDED = 4;

  // Link FSM state encoding
  typedef enum logic {
    ST_WAIT_BC = 1'b0,
    ST_ACTIVE  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/serial_to_parallel_l1.sv
// Serial-to-parallel L1 Rx stage: shifts in MSB-first bits on clk_16f,
// frames fixed 8-bit words and gates payload words behind COMMA alignment.
module serial_to_parallel_l1
  import serial_to_parallel_l1_pkg::*;
#(
  parameter logic [7:0] COMMA     = RX_COMMA,
  parameter int         BC_NEEDED = RX_BC_NEEDED
) (
  input  logic       clk_16f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int BCW = $clog2(BC_NEEDED + 1);
  localparam logic [BCW-1:0] BC_MAX = BCW'(BC_NEEDED);

  logic [7:0]     shift_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     word;
  logic           word_edge;

  rx_state_e      state_q, state_d;
  logic [BCW-1:0] bc_q, bc_d, bc_inc;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;

  // The word completes with the bit sampled on this edge, so no extra cycle.
  assign word      = {shift_q[6:0], data_in};
  assign word_edge = (bit_cnt_q == 3'd7);
  assign bc_inc    = (bc_q == BC_MAX) ? bc_q : bc_q + BCW'(1);

  // Bit capture and free-running word framing counter (no bit slipping)
  always_ff @(posedge clk_16f or negedge reset_L) begin
    if (!reset_L) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      shift_q   <= word;
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  // Link FSM and output registers, updated only on word edges
  always_ff @(posedge clk_16f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_WAIT_BC;
      bc_q    <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: count consecutive COMMAs, then pass non-COMMA words as payload
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (word_edge) begin
      data_d = word;
      case (state_q)
        ST_WAIT_BC: begin
          valid_d = 1'b0;
          if (word == COMMA) begin
            bc_d = bc_inc;
            if (bc_inc == BC_MAX) state_d = ST_ACTIVE;
          end else begin
            bc_d = '0;
          end
        end
        ST_ACTIVE: begin
          // COMMA in ACTIVE is idle filler; the link stays up until reset
          valid_d = (word != COMMA);
        end
        default: begin
          state_d = ST_WAIT_BC;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_serial_to_parallel_l1.sv
// Directed bench for serial_to_parallel_l1: alignment, payload passing,
// async reset mid-word and a scoreboarded random payload run.
module tb_serial_to_parallel_l1;

  logic       clk_16f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int errors = 0;
  int checks = 0;

  serial_to_parallel_l1 dut (
    .clk_16f  (clk_16f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_16f = ~clk_16f;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the top n bits of w MSB first; each bit is sampled by one rising edge
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      data_in = w[i];
      @(posedge clk_16f);
      #1;
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w, 8);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, v});
    chk({tag, ".active"}, {7'd0, active}, {7'd0, a});
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    data_in = 1'b0;
    repeat (2) @(posedge clk_16f);
    #1;
    chk_out("reset", 8'h00, 1'b0, 1'b0);
    reset_L = 1'b1;
  endtask

  logic [7:0] sb_q[$];
  logic [7:0] rw, exp_w;

  initial begin
    // Reset state
    do_reset();

    // Four COMMAs align the link (edge 32), then payload 0x5A at edge 40
    for (int k = 1; k <= 3; k++) begin
      send_word(8'hBC);
      chk_out($sformatf("align_bc%0d", k), 8'hBC, 1'b0, 1'b0);
    end
    send_word(8'hBC);
    chk_out("align_bc4", 8'hBC, 1'b0, 1'b1);
    send_bits(8'h5A, 4);
    chk_out("midword_hold", 8'hBC, 1'b0, 1'b1);
    send_bits(8'hA0, 4);  // low nibble of 0x5A: bits 3..0 = 1010
    chk_out("payload_5a", 8'h5A, 1'b1, 1'b1);

    // ACTIVE: payload, idle filler, payload
    send_word(8'hFF);
    chk_out("act_ff", 8'hFF, 1'b1, 1'b1);
    send_word(8'hBC);
    chk_out("act_idle", 8'hBC, 1'b0, 1'b1);
    send_word(8'h00);
    chk_out("act_00", 8'h00, 1'b1, 1'b1);

    // Reset pulse in the middle of bit 3 of a word while ACTIVE
    send_bits(8'hC3, 4);
    data_in = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 1'b0, 1'b0);
    @(posedge clk_16f);
    @(posedge clk_16f);
    #1 reset_L = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      send_word(8'hBC);
      chk_out($sformatf("realign_bc%0d", k), 8'hBC, 1'b0, 1'b0);
    end
    send_word(8'hBC);
    chk_out("realign_bc4", 8'hBC, 1'b0, 1'b1);

    // Broken COMMA run: 3 x BC, 0x11, 4 x BC -> active only at edge 64
    do_reset();
    repeat (3) send_word(8'hBC);
    chk_out("brk_bc3", 8'hBC, 1'b0, 1'b0);
    send_word(8'h11);
    chk_out("brk_11", 8'h11, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      send_word(8'hBC);
      chk_out($sformatf("brk_rebc%0d", k), 8'hBC, 1'b0, 1'b0);
    end
    send_word(8'hBC);
    chk_out("brk_edge64", 8'hBC, 1'b0, 1'b1);

    // Continuous random payload words against a scoreboard
    for (int k = 0; k < 16; k++) begin
      rw = 8'($urandom_range(0, 255));
      if (rw == 8'hBC) rw = 8'h3C;
      sb_q.push_back(rw);
      send_word(rw);
      exp_w = sb_q.pop_front();
      chk_out($sformatf("rand%0d", k), exp_w, 1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
